cpu_bus_ctrl: RTL and testbench

- Sits directly downstream of the CPU's external bus port.
- Detects each CPU bus strobe and latches the address, write data and write-enable.
- Decodes the address against one device window. Mapped accesses go to a device-side req/ack handshake; unmapped or timed-out accesses complete on their own.
- Returns read data plus a one-cycle data-ready pulse, which the CPU consumes as its data-ready input.

---
 rtl/cpu_bus_pkg.sv | 14 +
 rtl/cpu_bus_ctrl_timeout_ctr.sv | 26 ++
 rtl/cpu_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_bus_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus controller: state encoding and default widths.
package cpu_bus_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_DW = 32;
  localparam logic [31:0] DEFAULT_OPEN_BUS = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/cpu_bus_ctrl_timeout_ctr.sv
// Device-ack timeout counter: clear to zero, count up while enabled, flag the terminal count.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus port controller: strobe edge detect, single-window decode, device req/ack
// bridge with timeout, and a one-cycle data-ready completion pulse back to the CPU.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int              AW       = DEFAULT_AW,
  parameter int              DW       = DEFAULT_DW,
  parameter logic [AW-1:0]   DEV_BASE = AW'(32'h0001_0000),
  parameter logic [AW-1:0]   DEV_SIZE = AW'(32'h0001_0000),
  parameter int unsigned     TIMEOUT  = 16,
  parameter logic [DW-1:0]   OPEN_BUS = DW'(DEFAULT_OPEN_BUS)
) (
  input  logic          i_cpu_clk,
  input  logic          i_rst,
  input  logic          i_bus_clk,
  input  logic          i_bus_we,
  input  logic [AW-1:0] i_bus_addr,
  input  logic [DW-1:0] i_bus_data,
  output logic [DW-1:0] o_bus_data,
  output logic          o_bus_data_ready,
  output logic          o_dev_req,
  output logic          o_dev_we,
  output logic [AW-1:0] o_dev_addr,
  output logic [DW-1:0] o_dev_wdata,
  input  logic [DW-1:0] i_dev_rdata,
  input  logic          i_dev_ack,
  output logic          o_err,
  output logic          o_overrun,
  output logic          o_busy,
  output logic [1:0]    o_dbg_state
);

  bus_state_e    state;
  logic          bus_clk_low_q;
  logic          strobe_edge;
  logic [AW-1:0] offset;
  logic          hit;
  logic          ctr_clr;
  logic          ctr_en;
  logic          ctr_tc;

  // Records that the strobe was seen low; cleared by reset so a strobe already
  // high when reset releases never counts as a rising edge.
  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      bus_clk_low_q <= 1'b0;
    end else begin
      bus_clk_low_q <= ~i_bus_clk;
    end
  end

  assign strobe_edge = i_bus_clk & bus_clk_low_q;

  // Unsigned wrap makes addresses below DEV_BASE decode as misses.
  assign offset = i_bus_addr - DEV_BASE;
  assign hit    = (offset < DEV_SIZE);

  assign ctr_clr = (state == ST_IDLE);
  assign ctr_en  = (state == ST_REQ) && !i_dev_ack;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk (i_cpu_clk),
    .rst (i_rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  // Device handshake: o_dev_req rises with stable we/addr/wdata and holds until the
  // cycle i_dev_ack is sampled high (or the timeout fires); ack is ignored while req=0.
  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      o_bus_data       <= '0;
      o_bus_data_ready <= 1'b0;
      o_err            <= 1'b0;
      o_overrun        <= 1'b0;
      o_dev_req        <= 1'b0;
      o_dev_we         <= 1'b0;
      o_dev_addr       <= '0;
      o_dev_wdata      <= '0;
    end else begin
      o_bus_data_ready <= 1'b0;
      o_err            <= 1'b0;
      if (strobe_edge && state != ST_IDLE) begin
        o_overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (strobe_edge) begin
            if (hit) begin
              o_dev_req   <= 1'b1;
              o_dev_we    <= i_bus_we;
              o_dev_addr  <= offset;
              o_dev_wdata <= i_bus_data;
              state       <= ST_REQ;
            end else begin
              o_bus_data_ready <= 1'b1;
              o_err            <= 1'b1;
              o_bus_data       <= OPEN_BUS;
              state            <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          if (i_dev_ack) begin
            o_dev_req        <= 1'b0;
            o_bus_data_ready <= 1'b1;
            o_bus_data       <= o_dev_we ? '0 : i_dev_rdata;
            state            <= ST_RESP;
          end else if (ctr_tc) begin
            o_dev_req        <= 1'b0;
            o_bus_data_ready <= 1'b1;
            o_err            <= 1'b1;
            o_bus_data       <= OPEN_BUS;
            state            <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level model of decode, ack timing and timeout.
module tb_cpu_bus_ctrl;

  localparam logic [31:0] DEV_BASE = 32'h0001_0000;
  localparam logic [31:0] DEV_SIZE = 32'h0001_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] OPEN_BUS = 32'hFFFF_FFFF;
  localparam int          NO_ACK   = 1000;

  logic        clk;
  logic        rst;
  logic        bus_clk;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        dev_req;
  logic        dev_we;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        dev_ack;
  logic        err;
  logic        overrun;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_overrun = 1'b0;
  logic [32:0] exp_q[$];

  cpu_bus_ctrl #(
    .AW(32), .DW(32), .DEV_BASE(DEV_BASE), .DEV_SIZE(DEV_SIZE),
    .TIMEOUT(TIMEOUT), .OPEN_BUS(OPEN_BUS)
  ) dut (
    .i_cpu_clk        (clk),
    .i_rst            (rst),
    .i_bus_clk        (bus_clk),
    .i_bus_we         (bus_we),
    .i_bus_addr       (bus_addr),
    .i_bus_data       (bus_wdata),
    .o_bus_data       (bus_rdata),
    .o_bus_data_ready (bus_ready),
    .o_dev_req        (dev_req),
    .o_dev_we         (dev_we),
    .o_dev_addr       (dev_addr),
    .o_dev_wdata      (dev_wdata),
    .i_dev_rdata      (dev_rdata),
    .i_dev_ack        (dev_ack),
    .o_err            (err),
    .o_overrun        (overrun),
    .o_busy           (busy),
    .o_dbg_state      (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver + monitor for one CPU transaction; expectations come from the
  // transaction-level rules (decode window, ack cycle vs. timeout).
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int ack_cycle, input logic [31:0] rdata, input bit poke_overrun);
    logic [31:0] off;
    logic        hit;
    int          exp_lat;
    int          exp_req;
    int          lat;
    int          req_cycles;
    int          pulses;
    bit          dev_bad;
    off = addr - DEV_BASE;
    hit = (off < DEV_SIZE);
    if (!hit) begin
      exp_lat = 1;
      exp_req = 0;
      exp_q.push_back({1'b1, OPEN_BUS});
    end else if (ack_cycle <= TIMEOUT) begin
      exp_lat = 1 + ack_cycle;
      exp_req = ack_cycle;
      exp_q.push_back({1'b0, (we ? 32'h0 : rdata)});
    end else begin
      exp_lat = 1 + TIMEOUT;
      exp_req = TIMEOUT;
      exp_q.push_back({1'b1, OPEN_BUS});
    end
    if (poke_overrun) exp_overrun = 1'b1;

    @(negedge clk);
    bus_clk   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    lat = 0;
    req_cycles = 0;
    pulses = 0;
    dev_bad = 1'b0;
    for (int c = 1; c <= TIMEOUT + 6; c++) begin
      @(negedge clk);
      dev_ack   = 1'b0;
      dev_rdata = $urandom;
      if (c == 1 || c == 4) bus_clk = 1'b0;
      if (poke_overrun && c == 3) bus_clk = 1'b1;
      if (bus_ready) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          if (exp_q.size() == 0) check_eq("spurious_ready", 1, 0);
          else check_eq("resp_err_data", {err, bus_rdata}, exp_q.pop_front());
        end
      end
      if (dev_req) begin
        req_cycles++;
        if ({dev_we, dev_addr, dev_wdata} !== {we, off, wdata}) dev_bad = 1'b1;
        if (req_cycles == ack_cycle) begin
          dev_ack   = 1'b1;
          dev_rdata = rdata;
        end
      end
    end
    check_eq("resp_missing", exp_q.size(), 0);
    exp_q.delete();
    check_eq("ready_latency", lat, exp_lat);
    check_eq("ready_pulses", pulses, 1);
    check_eq("req_cycles", req_cycles, exp_req);
    if (hit) check_eq("dev_fields_stable", dev_bad, 0);
    check_eq("overrun", overrun, exp_overrun);
    check_eq("idle_after", busy, 0);
  endtask

  initial begin
    bit q_req;
    bit q_rdy;
    rst = 1'b1;
    bus_clk = 1'b0;
    bus_we = 1'b0;
    bus_addr = '0;
    bus_wdata = '0;
    dev_rdata = '0;
    dev_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctrl", {bus_ready, dev_req, err, overrun, busy}, 5'b0);
    check_eq("reset_data", bus_rdata, 0);
    check_eq("reset_dev", {dev_we, dev_addr, dev_wdata}, 65'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed scenarios
    run_txn(32'h0001_0004, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h0001_FFFC, 1'b1, 32'h1234_5678, 5, 32'hCAFE_0000, 1'b0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, 1, 32'h1111_1111, 1'b0);
    run_txn(32'h0002_0000, 1'b1, 32'hABCD_0001, 1, 32'h2222_2222, 1'b0);
    run_txn(32'h0001_0100, 1'b0, 32'h0, NO_ACK, 32'h0, 1'b0);
    run_txn(32'h0001_0200, 1'b0, 32'h0, TIMEOUT, 32'h5A5A_5A5A, 1'b0);
    run_txn(32'h0001_0300, 1'b0, 32'h0, 5, 32'h7777_8888, 1'b1);

    // Randomized transactions over hits, wraps below the window and misses above it
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = DEV_BASE + $urandom_range(0, 32'h0000_FFFF);
        1: a = $urandom;
        2: a = DEV_BASE - $urandom_range(1, 16);
        default: a = DEV_BASE + DEV_SIZE - 32'd8 + $urandom_range(0, 16);
      endcase
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 20), $urandom, 1'b0);
    end

    // Reset in the middle of a request
    @(negedge clk);
    bus_clk = 1'b1;
    bus_we = 1'b0;
    bus_addr = 32'h0001_0040;
    @(negedge clk);
    bus_clk = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("req_before_reset", dev_req, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("req_async_drop", dev_req, 0);
    check_eq("overrun_cleared", overrun, 0);
    check_eq("busy_async_drop", busy, 0);
    exp_overrun = 1'b0;
    bus_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_req = 1'b0;
    q_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dev_req) q_req = 1'b1;
      if (bus_ready) q_rdy = 1'b1;
    end
    check_eq("no_req_after_release", q_req, 0);
    check_eq("no_ready_after_release", q_rdy, 0);
    bus_clk = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(32'h0001_0008, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
